// File: rtl/rom_reader_pkg.sv
// Shared definitions for the ROM stream reader.
//   state_e   : request FSM states (IDLE / FETCH / DRAIN)
//   ROM_DEPTH : number of words in the weight ROM
package rom_reader_pkg;

  localparam int unsigned ROM_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream from the ROM reader to the PE array weight loader.
//   m_data_o  : stream word
//   m_valid_o : word valid
//   m_ready_i : downstream ready
//   m_last_o  : final word of a request
// master = reader side, slave = consumer side.
interface rom_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic                  m_last_o;

  modport master (output m_data_o, output m_valid_o, output m_last_o, input m_ready_i);
  modport slave  (input m_data_o, input m_valid_o, input m_last_o, output m_ready_i);
endinterface

// File: rtl/rom_reader_buf.sv
// BUF_DEPTH x (DATA_WIDTH+1) synchronous FIFO holding {last, data} words.
// The head entry is read straight from the storage registers, so the stream
// outputs are registered.
//   clk, rst     : clock, synchronous active-high reset (clears storage too)
//   push_i       : write {push_last_i, push_data_i}; caller guarantees !full_o || pop_i
//   pop_i        : discard head entry; caller guarantees !empty_o
//   full_o       : no free entry
//   empty_o      : no stored entry
//   head_data_o  : head word data
//   head_last_o  : head word last flag
module rom_reader_buf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_last_o
);
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(BUF_DEPTH);

  logic [DATA_WIDTH:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [PTR_W:0]      count_q;

  assign full_o      = (count_q == FULL_CNT);
  assign empty_o     = (count_q == '0);
  assign head_data_o = mem_q[rptr_q][DATA_WIDTH-1:0];
  assign head_last_o = mem_q[rptr_q][DATA_WIDTH];

  // Pointers wrap naturally because BUF_DEPTH is a power of two. A push into a
  // full buffer with a simultaneous pop overwrites the slot being popped, which
  // is safe because the pop reads the old contents at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= {push_last_i, push_data_i};
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_i) rptr_q <= rptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/rom_stream_reader.sv
// Reader for the asynchronous-read weight ROM. A start pulse walks len_i
// consecutive addresses from base_i (wrapping mod ROM depth), captures the
// same-cycle ROM data and streams it out through a small rate-matching buffer.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : request pulse, sampled only in IDLE
//   base_i       : first ROM address
//   len_i        : word count, 0..ROM depth
//   busy_o       : request in progress
//   done_o       : 1-cycle pulse after the last word is accepted (or after a len 0 start)
//   rom_addr_o   : registered ROM address
//   rom_data_i   : combinational ROM data for rom_addr_o
//   m_if         : valid/ready output stream (master)
//   checksum_o   : XOR of words transferred in the current request
//                  (only with `ROM_READER_CHECKSUM_EN defined)
module rom_stream_reader
  import rom_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = $clog2(ROM_DEPTH),
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  rom_stream_reader_if.master   m_if
`ifdef ROM_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum_o
`endif
);
  localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rem_q;
  logic                  busy_q, done_q;

  logic                  buf_full, buf_empty, push, pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;

  assign pop  = m_if.m_valid_o && m_if.m_ready_i;
  // The ROM is only addressed when the word can be stored this very cycle.
  assign push = (state_q == FETCH) && (!buf_full || pop);

  rom_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (rom_data_i),
    .push_last_i (rem_q == REM_ONE),
    .pop_i       (pop),
    .full_o      (buf_full),
    .empty_o     (buf_empty),
    .head_data_o (head_data),
    .head_last_o (head_last)
  );

  assign m_if.m_valid_o = !buf_empty;
  assign m_if.m_data_o  = head_data;
  assign m_if.m_last_o  = head_last;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign rom_addr_o     = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q  <= base_i;
              rem_q   <= len_i;
              busy_q  <= 1'b1;
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (push) begin
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == REM_ONE) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // The flagged last word is the only entry left once it is popped.
          if (pop && head_last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
  assign checksum_o = csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q ^ head_data;
    end
  end
`endif
endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [5:0]  base_i;
  logic [6:0]  len_i;
  logic        busy_o, done_o;
  logic [5:0]  rom_addr_o;
  logic [31:0] rom_data_i;
`ifdef ROM_READER_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif

  int checks = 0;
  int errors = 0;

  rom_stream_reader_if #(.DATA_WIDTH(32)) s_if ();

  always #5 clk = ~clk;

  assign rom_data_i = 32'hA500_0000 | {26'd0, rom_addr_o};

  rom_stream_reader #(
    .ADDR_WIDTH (6),
    .DATA_WIDTH (32),
    .BUF_DEPTH  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .base_i     (base_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .m_if       (s_if)
`ifdef ROM_READER_CHECKSUM_EN
    ,
    .checksum_o (checksum_o)
`endif
  );

  task automatic check_all_zero(input string nm);
    checks++;
    if ({busy_o, done_o, s_if.m_valid_o, s_if.m_last_o} !== 4'b0000) begin
      errors++;
      $display("FAIL %s flags: got busy/done/valid/last=%b expected 0000", nm,
               {busy_o, done_o, s_if.m_valid_o, s_if.m_last_o});
    end
    checks++;
    if (rom_addr_o !== 6'd0 || s_if.m_data_o !== 32'd0) begin
      errors++;
      $display("FAIL %s addr/data: got addr=%h data=%h expected 0/0", nm, rom_addr_o, s_if.m_data_o);
    end
  endtask

  task automatic start_req(input logic [5:0] b, input logic [6:0] l);
    @(negedge clk);
    base_i  = b;
    len_i   = l;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready 101010, low 5 cycles, then high.
  // inj: extra start pulse (base 10, len 3) while busy, which must be ignored.
  task automatic run_stream(input logic [5:0] b, input logic [6:0] l, input int mode,
                            input bit inj, input string nm);
    int          k = 0;
    int          first = -1;
    int          done_cyc = -1;
    logic [31:0] exp_d;
    logic [31:0] csum = 32'd0;
    logic [31:0] prev_d = 32'd0;
    logic        prev_last = 1'b0;
    logic        stalled = 1'b0;
    logic [5:0]  a;
    start_req(b, l);
    checks++;
    if (s_if.m_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s start_latency: got valid=%b busy=%b expected valid=0 busy=1", nm,
               s_if.m_valid_o, busy_o);
    end
    for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
      if (mode == 0)     s_if.m_ready_i = 1'b1;
      else if (cyc < 6)  s_if.m_ready_i = (cyc % 2 == 0);
      else if (cyc < 11) s_if.m_ready_i = 1'b0;
      else               s_if.m_ready_i = 1'b1;
      if (inj) begin
        start_i = (cyc == 2);
        if (cyc == 2) begin
          base_i = 6'd10;
          len_i  = 7'd3;
        end
      end
      if (stalled) begin
        checks++;
        if (s_if.m_valid_o !== 1'b1 || s_if.m_data_o !== prev_d || s_if.m_last_o !== prev_last) begin
          errors++;
          $display("FAIL %s stall_hold: got valid=%b data=%h last=%b expected 1 %h %b", nm,
                   s_if.m_valid_o, s_if.m_data_o, s_if.m_last_o, prev_d, prev_last);
        end
      end
      if (s_if.m_valid_o === 1'b1 && s_if.m_ready_i === 1'b1) begin
        a     = b + k[5:0];
        exp_d = 32'hA500_0000 | {26'd0, a};
        checks++;
        if (s_if.m_data_o !== exp_d) begin
          errors++;
          $display("FAIL %s word%0d: got %h expected %h", nm, k, s_if.m_data_o, exp_d);
        end
        checks++;
        if (s_if.m_last_o !== (k == int'(l) - 1)) begin
          errors++;
          $display("FAIL %s last%0d: got %b expected %b", nm, k, s_if.m_last_o, (k == int'(l) - 1));
        end
        csum ^= exp_d;
        if (first < 0) first = cyc;
        k++;
      end
      stalled   = s_if.m_valid_o && !s_if.m_ready_i;
      prev_d    = s_if.m_data_o;
      prev_last = s_if.m_last_o;
      if (done_o === 1'b1) begin
        done_cyc = cyc;
        checks++;
        if (busy_o !== 1'b0 || s_if.m_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL %s at_done: got busy=%b valid=%b expected 0 0", nm, busy_o, s_if.m_valid_o);
        end
`ifdef ROM_READER_CHECKSUM_EN
        checks++;
        if (checksum_o !== csum) begin
          errors++;
          $display("FAIL %s checksum: got %h expected %h", nm, checksum_o, csum);
        end
`endif
      end else begin
        @(negedge clk);
      end
    end
    start_i = 1'b0;
    checks++;
    if (done_cyc < 0 || k != int'(l)) begin
      errors++;
      $display("FAIL %s completion: got words=%0d done_cycle=%0d expected words=%0d with done", nm,
               k, done_cyc, l);
    end
    if (mode == 0) begin
      checks++;
      if (first != 1 || done_cyc != int'(l) + 1) begin
        errors++;
        $display("FAIL %s timing: got first=%0d done=%0d expected first=1 done=%0d", nm,
                 first, done_cyc, int'(l) + 1);
      end
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || s_if.m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL %s after_done: got done=%b valid=%b busy=%b expected 0 0 0", nm,
                 done_o, s_if.m_valid_o, busy_o);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    base_i = '0;
    len_i = '0;
    s_if.m_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_stream(6'd0, 7'd6, 0, 1'b0, "t1_basic");
  endtask

  task automatic test_wrap();
    run_stream(6'd62, 7'd4, 0, 1'b0, "t2_wrap");
  endtask

  task automatic test_len_zero();
    start_req(6'd5, 7'd0);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || s_if.m_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t3_len0 done: got done=%b busy=%b valid=%b expected 1 0 0", done_o, busy_o,
               s_if.m_valid_o);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || s_if.m_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL t3_len0 after: got done=%b busy=%b valid=%b expected 0 0 0", done_o, busy_o,
                 s_if.m_valid_o);
      end
    end
  endtask

  task automatic test_backpressure();
    run_stream(6'd25, 7'd8, 1, 1'b1, "t4_backpressure");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    start_req(6'd0, 7'd6);
    s_if.m_ready_i = 1'b1;
    for (int cyc = 0; cyc < 20 && k < 3; cyc++) begin
      if (s_if.m_valid_o === 1'b1) k++;
      @(negedge clk);
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL t5_pre_reset words: got %0d expected 3", k);
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("t5_reset");
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || s_if.m_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL t5_no_done: got done=%b valid=%b expected 0 0", done_o, s_if.m_valid_o);
      end
    end
    run_stream(6'd0, 7'd6, 0, 1'b0, "t5_restart");
  endtask

`ifdef ROM_READER_CHECKSUM_EN
  task automatic test_checksum();
    run_stream(6'd0, 7'd4, 0, 1'b1, "t6_checksum");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_len_zero();
    test_backpressure();
    test_reset_mid();
`ifdef ROM_READER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
